// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants for the instruction-fetch stage. These are
//               the fetch FSM state encoding, the PC increment, and the
//               default reset PC and NOP word.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch control FSM states
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_NOP      = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction addresses must be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Bundles the fetch-stage signals: the hazard/branch controls,
//               the instruction-memory port, the IF/ID register contents and
//               the status outputs.
//               master : the fetch unit (drives o_*, receives i_*)
//               slave  : the surrounding pipeline / memory model
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if;
    logic        i_stall;
    logic        i_br_taken;
    logic [31:0] i_br_target;
    logic [31:0] i_imem_data;
    logic [31:0] o_imem_addr;
    logic [31:0] o_ifid_pc4;
    logic [31:0] o_ifid_instr;
    logic        o_ifid_valid;
    logic [31:0] o_fetch_cnt;
    logic        o_fault;

    modport master (
        input  i_stall, i_br_taken, i_br_target, i_imem_data,
        output o_imem_addr, o_ifid_pc4, o_ifid_instr, o_ifid_valid,
               o_fetch_cnt, o_fault
    );

    modport slave (
        output i_stall, i_br_taken, i_br_target, i_imem_data,
        input  o_imem_addr, o_ifid_pc4, o_ifid_instr, o_ifid_valid,
               o_fetch_cnt, o_fault
    );
endinterface
`default_nettype wire

// File: rtl/ifid_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_reg
// Description : IF/ID pipeline register. Supports load, hold and flush.
//               Flush has priority over load. Reset and flush both leave the
//               register holding NOP with valid cleared.
// Ports       : clk, reset_n (async, active low)
//               i_load / i_flush         - capture / squash controls
//               i_pc4 / i_instr          - next contents
//               o_pc4 / o_instr / o_valid - registered contents
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP = DEFAULT_NOP
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        i_load,
    input  wire logic        i_flush,
    input  wire logic [31:0] i_pc4,
    input  wire logic [31:0] i_instr,
    output logic      [31:0] o_pc4,
    output logic      [31:0] o_instr,
    output logic             o_valid
);

    logic [31:0] r_pc4;
    logic [31:0] r_instr;
    logic        r_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc4   <= 32'd0;
            r_instr <= NOP;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_pc4   <= 32'd0;
            r_instr <= NOP;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc4   <= i_pc4;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end
    end

    assign o_pc4   = r_pc4;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Instruction-fetch stage. Holds the PC and drives the
//               instruction-memory address. Selects PC+4 or a taken branch
//               target, fills the IF/ID register, and counts accepted
//               instructions. A misaligned branch target halts fetch and
//               raises a sticky fault that only reset clears.
// Ports       : clk, reset_n (async, active low)
//               bus (pc_fetch_unit_if.master) - stall/branch inputs,
//               imem port, IF/ID contents, fetch counter, fault flag
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP      = DEFAULT_NOP
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    pc_fetch_unit_if.master  bus
);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_cnt;
    logic        r_fault;

    logic        w_run;
    logic        w_bad_target;
    logic        w_trap;
    logic        w_redirect;
    logic        w_flush;
    logic        w_advance;
    logic [31:0] w_pc_plus4;

    // Branch and stall inputs only take effect in RUN. A taken branch
    // outranks a stall, and a misaligned target outranks the redirect.
    always_comb begin
        w_run        = (r_state == ST_RUN);
        w_bad_target = is_misaligned(bus.i_br_target);
        w_flush      = w_run && bus.i_br_taken;
        w_trap       = w_flush && w_bad_target;
        w_redirect   = w_flush && !w_bad_target;
        w_advance    = w_run && !bus.i_br_taken && !bus.i_stall;
        w_pc_plus4   = r_pc + PC_INC;   // wraps modulo 2^32
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BOOT;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN:  if (w_trap) r_state <= ST_HALT;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc        <= RESET_PC;
            r_fetch_cnt <= 32'd0;
            r_fault     <= 1'b0;
        end else begin
            if (w_redirect) begin
                r_pc <= bus.i_br_target;
            end else if (w_advance) begin
                r_pc <= w_pc_plus4;
            end
            if (w_advance) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_trap) begin
                r_fault <= 1'b1;
            end
        end
    end

    ifid_reg #(
        .NOP (NOP)
    ) u_ifid_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_advance),
        .i_flush (w_flush),
        .i_pc4   (w_pc_plus4),
        .i_instr (bus.i_imem_data),
        .o_pc4   (bus.o_ifid_pc4),
        .o_instr (bus.o_ifid_instr),
        .o_valid (bus.o_ifid_valid)
    );

    assign bus.o_imem_addr = r_pc;
    assign bus.o_fetch_cnt = r_fetch_cnt;
    assign bus.o_fault     = r_fault;

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage of the 5-stage pipelined CPU. Holds the program counter, drives the instruction-memory address, and selects between sequential PC+4 and the branch target produced by the branch-address adder. Fetched instructions go into the IF/ID pipeline register, which supports stall and flush. A misaligned branch target is trapped by a small control FSM.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP, 32'h0000_0000, instruction word written into IF/ID on flush/reset

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- i_stall  in  1  hazard-unit stall; hold PC and IF/ID
- i_br_taken  in  1  branch resolved taken this cycle (redirect)
- i_br_target  in  32  branch address from the branch-address adder
- i_imem_data  in  32  instruction word, combinational read of o_imem_addr
- o_imem_addr  out  32  current PC
- o_ifid_pc4  out  32  PC+4 of instruction held in IF/ID
- o_ifid_instr  out  32  instruction held in IF/ID
- o_ifid_valid  out  1  IF/ID holds a real instruction
- o_fetch_cnt  out  32  count of instructions accepted into IF/ID
- o_fault  out  1  sticky misaligned-target fault

One clock; reset is asynchronous and active-low (clk, reset_n).

## Operation
- FSM states: BOOT, RUN, HALT.
- Reset (async, reset_n=0): PC=RESET_PC, o_ifid_pc4=0, o_ifid_instr=NOP, o_ifid_valid=0, o_fetch_cnt=0, o_fault=0, state=BOOT.
- BOOT: one cycle, no IF/ID capture, PC held; next state RUN. i_br_taken and i_stall are ignored in BOOT.
- RUN, priority order per edge:
  - i_br_taken=1 and i_br_target[1:0]!=0: state becomes HALT, o_fault=1, PC held, IF/ID flushed (instr=NOP, valid=0).
  - i_br_taken=1, aligned: PC=i_br_target, IF/ID flushed. Redirect overrides i_stall.
  - i_stall=1: PC, IF/ID and counter hold.
  - Otherwise: PC=PC+4, IF/ID={PC+4, i_imem_data}, valid=1, o_fetch_cnt+1.
- HALT: all registers hold. Exit only through reset.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC+4 gives 0 with no carry out. o_fetch_cnt wraps modulo 2^32.
- o_imem_addr equals the PC register combinationally, with no extra latency.

## Timing
- Fetch latency: the instruction at address A appears on o_ifid_instr one edge after PC=A, if no stall or redirect.
- Redirect: i_br_taken sampled at edge N. After edge N, PC=target and valid=0. The target instruction is valid in IF/ID after edge N+1. Branch penalty is the flushed slot.
- Stall: hold lasts exactly while i_stall=1. There is no bubble after release.
- reset_n asserted mid-operation clears state immediately, with no clock needed. The first fetch is at the second rising edge after deassertion (BOOT + RUN).
- Inputs are sampled only on the rising clk edge.

## Structure
- Shared package fetch_pkg:
  - state encoding for BOOT, RUN, HALT
  - PC_INC = 32'd4
  - default NOP and RESET_PC constants
- One sub-module is natural: ifid_reg, the IF/ID pipeline register with load, hold (stall) and flush, and async reset to NOP/valid=0. PC register, incrementer, redirect mux, FSM and counter stay in the top.

## Test plan
- Reset then free-run with memory word = address: after the BOOT edge plus 3 edges, IF/ID holds instr 32'h8, pc4 32'hC, o_fetch_cnt=3.
- i_stall=1 for 2 cycles at PC=32'h10: PC stays 32'h10 and IF/ID is unchanged for both cycles. On the next edge, instr 32'h10 is captured.
- i_br_taken=1 with target 32'h100 while i_stall=1: PC=32'h100 and valid=0 on the next edge. Instr 32'h100 is valid one edge later. The counter does not increment during the flushed cycle.
- i_br_taken=1 with target 32'h102: o_fault=1 and state HALT. PC and counter stay frozen for 10 cycles and o_ifid_valid=0. After a reset_n pulse, the fault clears.
- PC=32'hFFFF_FFFC running freely: the next PC is 32'h0 and o_ifid_pc4=32'h0.
- reset_n pulsed low asynchronously between edges while in RUN: all outputs return to reset values before the next edge.
